// File: rtl/icache_dm_if.sv
// Fetch-side and bridge-side signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache's view; master is the CPU fetch stage plus the AXI bridge.
interface icache_dm_if;
    logic        valid;
    logic [31:0] addr;
    logic        uncached;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    modport master (
        output valid, addr, uncached, rd_rdy, ret_valid, ret_last, ret_data,
        input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
    );

    modport slave (
        input  valid, addr, uncached, rd_rdy, ret_valid, ret_last, ret_data,
        output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 4-word lines held in flops.
// Hits answer in the cycle after accept; misses refill a whole line, uncached fetches read one word.
module icache_dm #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic      clk,
    input  logic      resetn,
    icache_dm_if.slave bus
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 28 - INDEX_BITS;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [2:0] RD_LINE = 3'b100;
    localparam logic [2:0] RD_WORD = 3'b010;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [29:0]            req_word;
    logic                   req_unc;
    logic [1:0]             cnt;
    logic [31:0]            rdata_q;
    logic [LINES-1:0]       line_valid;
    logic [TAG_W-1:0]       tag_arr  [LINES];
    logic [31:0]            data_arr [LINES][4];

    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_W-1:0]       req_tag;
    logic [1:0]             off;
    logic                   hit_c;
    logic                   can_accept_c;
    logic                   accept_c;
    logic                   beat_c;

    assign idx          = req_word[1+INDEX_BITS:2];
    assign req_tag      = req_word[29:2+INDEX_BITS];
    assign off          = req_word[1:0];
    assign hit_c        = !req_unc && line_valid[idx] && (tag_arr[idx] == req_tag);
    assign can_accept_c = (state == S_IDLE) || ((state == S_LOOKUP) && hit_c);
    assign accept_c     = bus.valid && can_accept_c;
    assign beat_c       = (state == S_REFILL) && bus.ret_valid;

    // Next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        bus.addr_ok = can_accept_c;
        bus.data_ok = 1'b0;
        bus.rdata   = rdata_q;
        bus.rd_req  = 1'b0;
        bus.rd_type = req_unc ? RD_WORD : RD_LINE;
        bus.rd_addr = req_unc ? {req_word, 2'b00} : {req_word[29:2], 4'b0000};
        case (state)
            S_IDLE: begin
                if (bus.valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_c) begin
                    bus.data_ok = 1'b1;
                    bus.rdata   = data_arr[idx][off];
                    state_nxt   = bus.valid ? S_LOOKUP : S_IDLE;
                end else begin
                    state_nxt   = S_MISS;
                end
            end
            S_MISS: begin
                bus.rd_req = 1'b1;
                if (bus.rd_rdy) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                if (bus.ret_valid && bus.ret_last) state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.data_ok = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state; valid bits are only set on the final beat so a partial line is never seen
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            req_word   <= '0;
            req_unc    <= 1'b0;
            cnt        <= 2'd0;
            rdata_q    <= 32'd0;
            line_valid <= '0;
        end else begin
            state <= state_nxt;
            if (accept_c) begin
                req_word <= bus.addr[31:2];
                req_unc  <= bus.uncached;
            end
            if ((state == S_MISS) && bus.rd_rdy) cnt <= 2'd0;
            if (beat_c) begin
                if (!req_unc) cnt <= cnt + 2'd1;
                if (req_unc || (cnt == off)) rdata_q <= bus.ret_data;
                if (bus.ret_last && !req_unc) line_valid[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage needs no reset
    always_ff @(posedge clk) begin
        if (beat_c && !req_unc) begin
            data_arr[idx][cnt] <= bus.ret_data;
            if (bus.ret_last) tag_arr[idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, held-valid hits, mid-refill reset,
// then random fetches against a line-level cache model and a behavioural AXI-bridge responder.
module tb_icache_dm;
    localparam int unsigned NLINES = 64;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    icache_dm_if bus();

    icache_dm #(.INDEX_BITS(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Bridge knobs (written by main) and bridge observations (written by bridge)
    int rdy_delay = 0;
    int beat_gap  = 0;
    int br_phase  = 0;
    int br_wait   = 0;
    int br_beat   = 0;
    int br_nbeats = 0;
    int br_gap_left = 0;
    int br_strays = 0;
    int rd_cnt    = 0;
    int br_unstable = 0;
    logic [31:0] br_addr = 32'd0;
    logic [2:0]  br_type = 3'd0;

    bit          mvalid [NLINES];
    int unsigned mtag   [NLINES];

    typedef struct {
        logic [31:0] addr;
        logic        unc;
        logic        hit;
        logic [31:0] data;
        logic [31:0] rd_addr;
        logic [2:0]  rd_type;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h1C000000: return 32'h11;
            32'h1C000004: return 32'h22;
            32'h1C000008: return 32'h33;
            32'h1C00000C: return 32'h44;
            32'h1C000400: return 32'h55;
            32'hBFAF8004: return 32'hDEAD;
            default:      return a ^ 32'h1234_5678;
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NLINES; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = 0;
        end
    endfunction

    // Whole-line cache model: returns whether the fetch hits, installs the line on a cached miss
    function automatic bit model_access(input logic [31:0] a, input logic u);
        int unsigned line = int'(a) >> 4;
        int unsigned ix   = line % NLINES;
        int unsigned tg   = line / NLINES;
        bit h = !u && mvalid[ix] && (mtag[ix] == tg);
        if (!u && !h) begin
            mvalid[ix] = 1'b1;
            mtag[ix]   = tg;
        end
        return h;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic u, input logic exp_hit,
                            input logic [31:0] exp_data, input logic [31:0] exp_rd_addr,
                            input logic [2:0] exp_rd_type, input string nm);
        int lat;
        int rd0;
        int unst0;
        rd0   = rd_cnt;
        unst0 = br_unstable;
        lat   = 0;
        while (!bus.addr_ok && lat < 50) begin step(); lat++; end
        check({nm, " addr_ok"}, 32'(bus.addr_ok), 32'd1);
        bus.valid = 1'b1; bus.addr = a; bus.uncached = u;
        step();
        bus.valid = 1'b0;
        lat = 1;
        while (!bus.data_ok && lat < 300) begin step(); lat++; end
        check({nm, " data_ok"}, 32'(bus.data_ok), 32'd1);
        check({nm, " rdata"}, bus.rdata, exp_data);
        check({nm, " hit_latency"}, 32'(lat == 1), 32'(exp_hit));
        check({nm, " reads"}, 32'(rd_cnt - rd0), exp_hit ? 32'd0 : 32'd1);
        if (!exp_hit) begin
            check({nm, " rd_addr"}, br_addr, exp_rd_addr);
            check({nm, " rd_type"}, 32'(br_type), 32'(exp_rd_type));
            check({nm, " rd_stable"}, 32'(br_unstable - unst0), 32'd0);
        end
        step();
        check({nm, " data_ok_pulse"}, 32'(bus.data_ok), 32'd0);
    endtask

    task automatic fetch_model(input logic [31:0] a, input logic u, input string nm);
        logic        h;
        logic [31:0] ra;
        h  = model_access(a, u);
        ra = u ? (a & 32'hFFFF_FFFC) : (a & 32'hFFFF_FFF0);
        do_fetch(a, u, h, mem_word(a & 32'hFFFF_FFFC), ra, u ? 3'b010 : 3'b100, nm);
    endtask

    // Behavioural bridge: accepts after rdy_delay cycles, returns beats with beat_gap idle cycles
    initial begin
        bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = 32'd0;
        forever begin
            step();
            bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
            if (!resetn) begin
                if (br_phase == 2) begin br_phase = 3; br_strays = 2; end
                else if (br_phase == 1) br_phase = 0;
            end else if (br_phase == 3) begin
                bus.ret_valid = 1'b1; bus.ret_last = 1'b1; bus.ret_data = 32'h0BAD_0BAD;
                br_strays--;
                if (br_strays == 0) br_phase = 0;
            end else if (br_phase == 2) begin
                if (br_gap_left > 0) br_gap_left--;
                else begin
                    bus.ret_valid = 1'b1;
                    bus.ret_data  = mem_word(br_addr + 32'(4 * br_beat));
                    bus.ret_last  = (br_beat == br_nbeats - 1);
                    br_beat++;
                    br_gap_left = beat_gap;
                    if (br_beat == br_nbeats) br_phase = 0;
                end
            end else begin
                if (br_phase == 0 && bus.rd_req) begin
                    br_phase = 1; br_wait = rdy_delay; br_addr = bus.rd_addr; br_type = bus.rd_type;
                end
                if (br_phase == 1) begin
                    if (!bus.rd_req || bus.rd_addr !== br_addr || bus.rd_type !== br_type) br_unstable++;
                    if (br_wait == 0) begin
                        bus.rd_rdy = 1'b1; br_phase = 2; br_beat = 0; br_gap_left = beat_gap;
                        br_nbeats = (br_type == 3'b100) ? 4 : 1;
                        rd_cnt++;
                    end else br_wait--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int lat;
        logic [31:0] a;
        logic [31:0] bases [3];
        vt[0] = '{32'h1C000008, 1'b0, 1'b0, 32'h33,       32'h1C000000, 3'b100};
        vt[1] = '{32'h1C00000C, 1'b0, 1'b1, 32'h44,       32'h0,        3'b100};
        vt[2] = '{32'h1C000400, 1'b0, 1'b0, 32'h55,       32'h1C000400, 3'b100};
        vt[3] = '{32'h1C000000, 1'b0, 1'b0, 32'h11,       32'h1C000000, 3'b100};
        vt[4] = '{32'h1C000004, 1'b0, 1'b1, 32'h22,       32'h0,        3'b100};
        vt[5] = '{32'hBFAF8004, 1'b1, 1'b0, 32'hDEAD,     32'hBFAF8004, 3'b010};
        vt[6] = '{32'hBFAF8004, 1'b1, 1'b0, 32'hDEAD,     32'hBFAF8004, 3'b010};
        vt[7] = '{32'h1C000408, 1'b0, 1'b0, 32'h0E345270, 32'h1C000400, 3'b100};
        bases[0] = 32'h1C000000; bases[1] = 32'h1C000400; bases[2] = 32'h2000_0000;

        model_clear();
        resetn = 1'b0; bus.valid = 1'b0; bus.addr = 32'd0; bus.uncached = 1'b0;
        repeat (3) step();
        check("reset addr_ok", 32'(bus.addr_ok), 32'd1);
        check("reset data_ok", 32'(bus.data_ok), 32'd0);
        check("reset rd_req", 32'(bus.rd_req), 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            rdy_delay = (i == 2) ? 5 : 0;
            void'(model_access(vt[i].addr, vt[i].unc));
            do_fetch(vt[i].addr, vt[i].unc, vt[i].hit, vt[i].data, vt[i].rd_addr,
                     vt[i].rd_type, $sformatf("vec%0d", i));
        end
        rdy_delay = 0;

        // Back-to-back hits with valid held high
        fetch_model(32'h1C000010, 1'b0, "b2b_fill");
        rd0 = rd_cnt;
        bus.valid = 1'b1; bus.addr = 32'h1C000010; bus.uncached = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = bus.addr;
            void'(model_access(a, 1'b0));
            step();
            check($sformatf("b2b%0d addr_ok", k), 32'(bus.addr_ok), 32'd1);
            check($sformatf("b2b%0d data_ok", k), 32'(bus.data_ok), 32'd1);
            check($sformatf("b2b%0d rdata", k), bus.rdata, mem_word(a));
            if (k < 3) bus.addr = a + 32'd4;
            else bus.valid = 1'b0;
        end
        step();
        check("b2b end data_ok", 32'(bus.data_ok), 32'd0);
        check("b2b reads", 32'(rd_cnt - rd0), 32'd0);

        // Reset in the middle of a refill
        beat_gap = 3;
        bus.valid = 1'b1; bus.addr = 32'h1C000020; bus.uncached = 1'b0;
        step();
        bus.valid = 1'b0;
        lat = 0;
        while (!(br_phase == 2 && br_beat >= 2) && lat < 100) begin step(); lat++; end
        check("midrefill reached", 32'(br_phase == 2 && br_beat >= 2), 32'd1);
        check("midrefill data_ok", 32'(bus.data_ok), 32'd0);
        resetn = 1'b0;
        step();
        step();
        check("midreset addr_ok", 32'(bus.addr_ok), 32'd1);
        check("midreset data_ok", 32'(bus.data_ok), 32'd0);
        check("midreset rd_req", 32'(bus.rd_req), 32'd0);
        check("midreset rdata", bus.rdata, 32'd0);
        resetn = 1'b1;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("stray%0d data_ok", k), 32'(bus.data_ok), 32'd0);
            check($sformatf("stray%0d addr_ok", k), 32'(bus.addr_ok), 32'd1);
        end
        beat_gap = 0;
        fetch_model(32'h1C000020, 1'b0, "after_reset_miss");
        fetch_model(32'h1C00000C, 1'b0, "after_reset_cold");

        // Randomised fetches over a few conflicting tags
        for (int n = 0; n < 120; n++) begin
            a = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 3) * 4);
            rdy_delay = $urandom_range(0, 3);
            beat_gap  = $urandom_range(0, 2);
            fetch_model(a, ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
